// File: rtl/fir_l3_block_former.sv
// rtl/fir_l3_block_former.sv - serial-to-parallel L=3 block former with block FIFO and zero-pad flush
module fir_l3_block_former #(
    parameter int DATA_IN_WIDTH = 16,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic signed [DATA_IN_WIDTH-1:0]   in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              flush,
    output logic signed [DATA_IN_WIDTH-1:0]   data_out_1,
    output logic signed [DATA_IN_WIDTH-1:0]   data_out_2,
    output logic signed [DATA_IN_WIDTH-1:0]   data_out_3,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [$clog2(FIFO_DEPTH):0]       fill_level
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FILL_W = PTR_W + 1;
    localparam int BLK_W  = 3 * DATA_IN_WIDTH;
    localparam logic [FILL_W-1:0] DEPTH_F = FILL_W'(FIFO_DEPTH);

    // Assembly state: slot counts samples already held for the current block.
    logic [1:0]               slot;
    logic [1:0]               slot_after_in;
    logic [DATA_IN_WIDTH-1:0] lane0;
    logic [DATA_IN_WIDTH-1:0] lane1;
    logic                     flush_pending;

    // Block FIFO storage; a block is {lane0, lane1, lane2} with lane0 in the MSBs.
    logic [BLK_W-1:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         wptr;
    logic [PTR_W-1:0]         rptr;
    logic [PTR_W-1:0]         wptr_next;
    logic [PTR_W-1:0]         rptr_next;
    logic [FILL_W-1:0]        fill_next;

    logic                     has_room;
    logic                     in_fire;
    logic                     out_fire;
    logic                     blk_push;
    logic                     flush_push;
    logic                     push;
    logic                     flush_set;
    logic [BLK_W-1:0]         push_data;
    logic [BLK_W-1:0]         head_next;
    logic [BLK_W-1:0]         head_q;

    assign out_valid  = (fill_level != '0);
    assign data_out_1 = head_q[BLK_W-1 -: DATA_IN_WIDTH];
    assign data_out_2 = head_q[2*DATA_IN_WIDTH-1 -: DATA_IN_WIDTH];
    assign data_out_3 = head_q[DATA_IN_WIDTH-1:0];

    // Handshake, push/pop decisions and next-state values; in_ready uses registered state only.
    always_comb begin
        has_room      = (fill_level < DEPTH_F);
        in_ready      = !flush_pending && ((slot != 2'd2) || has_room);
        in_fire       = in_valid && in_ready;
        out_fire      = out_valid && out_ready;

        // Completing a block and committing a flush are exclusive: flush_pending forces in_ready low.
        blk_push      = in_fire && (slot == 2'd2);
        flush_push    = flush_pending && has_room;
        push          = blk_push || flush_push;

        push_data     = {lane0, lane1, in_data};
        if (flush_push) begin
            push_data = {lane0, (slot == 2'd2) ? lane1 : {DATA_IN_WIDTH{1'b0}},
                         {DATA_IN_WIDTH{1'b0}}};
        end

        slot_after_in = slot;
        if (in_fire) begin
            slot_after_in = (slot == 2'd2) ? 2'd0 : slot + 2'd1;
        end

        // A flush only matters if samples remain after this cycle's input; a second flush is absorbed.
        flush_set     = flush && !flush_pending && (slot_after_in != 2'd0);

        wptr_next     = push     ? wptr + PTR_W'(1) : wptr;
        rptr_next     = out_fire ? rptr + PTR_W'(1) : rptr;

        case ({push, out_fire})
            2'b10:   fill_next = fill_level + FILL_W'(1);
            2'b01:   fill_next = fill_level - FILL_W'(1);
            default: fill_next = fill_level;
        endcase

        // The new head is the block being written only when it becomes the sole entry.
        if (fill_next == '0) begin
            head_next = '0;
        end else if (push && (fill_next == FILL_W'(1))) begin
            head_next = push_data;
        end else begin
            head_next = mem[rptr_next];
        end
    end

    // Slot counter, holding lanes and flush bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot          <= 2'd0;
            lane0         <= '0;
            lane1         <= '0;
            flush_pending <= 1'b0;
        end else begin
            if (flush_push) begin
                slot          <= 2'd0;
                flush_pending <= 1'b0;
            end else begin
                slot <= slot_after_in;
                if (flush_set) begin
                    flush_pending <= 1'b1;
                end
            end
            if (in_fire && (slot == 2'd0)) begin
                lane0 <= in_data;
            end
            if (in_fire && (slot == 2'd1)) begin
                lane1 <= in_data;
            end
        end
    end

    // FIFO pointers, occupancy and registered head block.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            fill_level <= '0;
            head_q     <= '0;
        end else begin
            wptr       <= wptr_next;
            rptr       <= rptr_next;
            fill_level <= fill_next;
            head_q     <= head_next;
        end
    end

    // Block storage write port; contents are don't-care until pushed since the head is gated by occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= push_data;
        end
    end

endmodule

// File: tb/tb_fir_l3_block_former.sv
// tb/tb_fir_l3_block_former.sv - directed self-checking bench for fir_l3_block_former
module tb_fir_l3_block_former;

    logic              clk;
    logic              reset;
    logic signed [15:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic signed [15:0] data_out_1;
    logic signed [15:0] data_out_2;
    logic signed [15:0] data_out_3;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        fill_level;

    int checks;
    int failures;

    fir_l3_block_former #(
        .DATA_IN_WIDTH (16),
        .FIFO_DEPTH    (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .data_out_1 (data_out_1),
        .data_out_2 (data_out_2),
        .data_out_3 (data_out_3),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fill_level (fill_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input string tag, input logic [15:0] v);
        chk(tag, {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        in_data  = v;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic chk_blk(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [1:0] fl);
        chk({tag, "_data"}, {16'd0, data_out_1, data_out_2, data_out_3}, {16'd0, a, b, c});
        chk({tag, "_valid"}, {63'd0, out_valid}, {63'd0, (fl != 2'd0)});
        chk({tag, "_fill"}, {62'd0, fill_level}, {62'd0, fl});
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk_blk("rst", 16'd0, 16'd0, 16'd0, 2'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // 1: streaming with out_ready high
        out_ready = 1'b1;
        send("t1_s1", 16'd1);
        send("t1_s2", 16'd2);
        chk("t1_nv", {63'd0, out_valid}, 64'd0);
        send("t1_s3", 16'd3);
        chk_blk("t1_b0", 16'd1, 16'd2, 16'd3, 2'd1);
        send("t1_s4", 16'd4);
        chk_blk("t1_pop", 16'd0, 16'd0, 16'd0, 2'd0);
        send("t1_s5", 16'd5);
        send("t1_s6", 16'd6);
        chk_blk("t1_b1", 16'd4, 16'd5, 16'd6, 2'd1);
        tick();
        chk_blk("t1_end", 16'd0, 16'd0, 16'd0, 2'd0);

        // 2: downstream stall fills the FIFO
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) send("t2_s", 16'(i));
        chk_blk("t2_full", 16'd1, 16'd2, 16'd3, 2'd2);
        send("t2_s7", 16'd7);
        send("t2_s8", 16'd8);
        chk("t2_stall_ready", {63'd0, in_ready}, 64'd0);
        in_valid = 1'b1;
        in_data  = 16'd9;
        tick();
        chk_blk("t2_hold", 16'd1, 16'd2, 16'd3, 2'd2);
        chk("t2_hold_ready", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
        tick();
        chk_blk("t2_rel1", 16'd4, 16'd5, 16'd6, 2'd1);
        chk("t2_rel_ready", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        chk_blk("t2_rel2", 16'd7, 16'd8, 16'd9, 2'd1);
        tick();
        chk_blk("t2_end", 16'd0, 16'd0, 16'd0, 2'd0);

        // 3: flush of a two-sample partial block
        send("t3_s1", 16'hFFFB);
        send("t3_s2", 16'd7);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t3_pend_ready", {63'd0, in_ready}, 64'd0);
        tick();
        chk_blk("t3_blk", 16'hFFFB, 16'd7, 16'd0, 2'd1);
        chk("t3_ready_back", {63'd0, in_ready}, 64'd1);
        tick();
        chk_blk("t3_pop", 16'd0, 16'd0, 16'd0, 2'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t3_empty_flush_ready", {63'd0, in_ready}, 64'd1);
        tick();
        chk_blk("t3_no_blk", 16'd0, 16'd0, 16'd0, 2'd0);

        // 4: flush while FIFO is full
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) send("t4_s", 16'(i));
        send("t4_s10", 16'd10);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        tick();
        chk("t4_wait_ready", {63'd0, in_ready}, 64'd0);
        chk_blk("t4_wait", 16'd1, 16'd2, 16'd3, 2'd2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_blk("t4_pop", 16'd4, 16'd5, 16'd6, 2'd1);
        chk("t4_pop_ready", {63'd0, in_ready}, 64'd0);
        tick();
        chk_blk("t4_padpush", 16'd4, 16'd5, 16'd6, 2'd2);
        chk("t4_ready_back", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        tick();
        chk_blk("t4_pad", 16'd10, 16'd0, 16'd0, 2'd1);
        send("t4_s11", 16'd11);
        chk_blk("t4_drain", 16'd0, 16'd0, 16'd0, 2'd0);
        send("t4_s12", 16'd12);
        send("t4_s13", 16'd13);
        chk_blk("t4_new", 16'd11, 16'd12, 16'd13, 2'd1);
        tick();

        // 5: reset mid-block with a block queued
        out_ready = 1'b0;
        send("t5_s7", 16'd7);
        send("t5_s8", 16'd8);
        send("t5_s9", 16'd9);
        send("t5_s1", 16'd1);
        send("t5_s2", 16'd2);
        chk_blk("t5_pre", 16'd7, 16'd8, 16'd9, 2'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_blk("t5_rst", 16'd0, 16'd0, 16'd0, 2'd0);
        chk("t5_rst_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        send("t5_s3", 16'd3);
        send("t5_s4", 16'd4);
        send("t5_s5", 16'd5);
        chk_blk("t5_blk", 16'd3, 16'd4, 16'd5, 2'd1);
        tick();

        // 6: signed extremes pass bit-exact
        send("t6_s1", 16'h8000);
        send("t6_s2", 16'h7FFF);
        send("t6_s3", 16'hFFFF);
        chk_blk("t6_blk", 16'h8000, 16'h7FFF, 16'hFFFF, 2'd1);
        tick();
        chk_blk("t6_end", 16'd0, 16'd0, 16'd0, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
